acumulador_controle: RTL and testbench
======================================

# acumulador_controle

Sequencer that drives the accumulator datapath (Load, Clear active-low, Transfer edge-triggered inputs) to sum a block of consecutive memory words. On Start it clears the accumulator, then fetches Count words from a synchronous-read memory starting at Base. For each word it pulses Load and then Transfer, and finally latches the accumulator output into Result with a one-cycle Done pulse. It sits between the top-level control and the accumulator, and owns the memory read port during an operation.

## Interface
- TAMANHO, 16, data width; must match the accumulator width
- ADDR_W, 8, memory address width and Count width

- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high
- Start  in  1  request; sampled only in IDLE
- Base  in  ADDR_W  first word address; captured when Start is accepted
- Count  in  ADDR_W  number of words; captured when Start is accepted; 0 allowed
- MemData  in  TAMANHO  memory read data, valid the cycle after MemRd
- Acc  in  TAMANHO  accumulator output (Saidas)
- MemRd  out  1  memory read strobe
- Addr  out  ADDR_W  memory address
- Load  out  1  accumulator operand-register clock, one-cycle pulse
- Clear  out  1  accumulator clear, active-low
- Transfer  out  1  accumulator sum-register clock, one-cycle pulse
- Busy  out  1  operation in progress
- Done  out  1  one-cycle completion pulse
- Result  out  TAMANHO  final sum, held until next Done
- Overflow  out  1  sticky carry-out flag (see Configuration)

## Operation
- FSM states: IDLE, LIMPA, LE, CARREGA, TRANSF, FIM.
- IDLE, Start=1: capture Base, Count; go to LIMPA. Otherwise stay.
- LIMPA: Clear=0; index i=0. Go to LE if Count≠0, else FIM.
- LE: MemRd=1, Addr=Base+i (modulo 2^ADDR_W, wraps silently) → CARREGA.
- CARREGA: Load=1 (MemData valid this cycle) → TRANSF.
- TRANSF: Transfer=1; i=i+1; go to LE if i+1<Count, else FIM.
- FIM: go to IDLE; on exit edge Result←Acc and Done register set.
- Strobes MemRd, Load, Clear, Transfer are Moore decodes of state, glitch-free (state one-hot or registered outputs); outside their state, MemRd=Load=Transfer=0 and Clear=1.
- Start while Busy is ignored, not queued.
- Addr holds its last value outside LE.
- Reset values: state IDLE, MemRd=0, Load=0, Transfer=0, Clear=0 during Reset (accumulator forced clear), Clear=1 from the first post-reset cycle, Addr=0, Busy=0, Done=0, Result=0, Overflow=0.
- Reset mid-operation aborts immediately; no Done is issued.

## Timing
- Start sampled at edge E0 → cycle 1 LIMPA; word k (k=0..N-1) occupies cycles 2+3k (LE), 3+3k (CARREGA), 4+3k (TRANSF).
- FIM in cycle 3N+2; Done=1 and Result valid in cycle 3N+3 (first IDLE cycle).
- Busy=1 in cycles 1..3N+2.
- Count=0: LIMPA cycle 1, FIM cycle 2, Done cycle 3 with Result=0.
- Start asserted in the Done cycle is accepted (back-to-back operations; Result of the previous operation is held).
- Throughput: 3 cycles per word plus 3 cycles overhead.

## Configuration
- ACUM_OVERFLOW_EN defined: in CARREGA, compute carry = bit TAMANHO of ({0,Acc}+{0,MemData}); Overflow is set sticky on carry and cleared when Start is accepted. It is reported alongside Result.
- Not defined: Overflow tied to 0 and no adder is instantiated.

## Structure
- Shared package: state encoding constants (ESTADO_IDLE … ESTADO_FIM) and the default TAMANHO/ADDR_W values, shared with the accumulator top level.
- One natural sub-module: contador_palavras (loadable ADDR_W index counter with terminal-count flag i+1==Count). The FSM lives in acumulador_controle.
- The accumulator itself is instantiated beside this block at top level, not inside it.

## Test plan
- Memory [10]=3, [11]=5, [12]=7; Base=10, Count=3, Start → exactly 3 Load and 3 Transfer pulses, Addr sequence 10, 11, 12, Done in cycle 12, Result=15.
- Count=0 → one Clear-low cycle, no MemRd/Load/Transfer, Done in cycle 3, Result=0.
- Base=255, Count=2, ADDR_W=8 → Addr 255 then 0 (wrap).
- Start pulsed repeatedly during Busy → ignored; a single Done. Start in the Done cycle → second operation begins; first Result is held until the second Done.
- Reset asserted in a CARREGA cycle → all outputs at reset values within the same cycle, no Done; a following Start runs cleanly.
- With ACUM_OVERFLOW_EN, TAMANHO=16: words 0xFFFF and 0x0002 → Result=0x0001, Overflow=1. Next Start clears Overflow. Without the macro, Overflow stays 0.

Source files
------------

// File: rtl/acumulador_controle_pkg.sv
// -----------------------------------------------------------------------------
// acumulador_controle_pkg
// Shared definitions for the accumulator sequencer and the accumulator top
// level. It holds the default datapath and address widths, and the one-hot
// state encoding constants used by the sequencer FSM.
// -----------------------------------------------------------------------------
package acumulador_controle_pkg;

   // Default widths; the accumulator top level uses the same values.
   localparam int TAMANHO_PADRAO = 16;
   localparam int ADDR_W_PADRAO  = 8;

   // One-hot state encoding. Every strobe is a registered decode of the next
   // state, so output glitches cannot appear.
   localparam logic [5:0] ESTADO_IDLE    = 6'b000001;
   localparam logic [5:0] ESTADO_LIMPA   = 6'b000010;
   localparam logic [5:0] ESTADO_LE      = 6'b000100;
   localparam logic [5:0] ESTADO_CARREGA = 6'b001000;
   localparam logic [5:0] ESTADO_TRANSF  = 6'b010000;
   localparam logic [5:0] ESTADO_FIM     = 6'b100000;

   typedef enum logic [5:0] {
      IDLE    = ESTADO_IDLE,
      LIMPA   = ESTADO_LIMPA,
      LE      = ESTADO_LE,
      CARREGA = ESTADO_CARREGA,
      TRANSF  = ESTADO_TRANSF,
      FIM     = ESTADO_FIM
   } estado_t;

endpackage

// File: rtl/acumulador_controle_contador.sv
// -----------------------------------------------------------------------------
// contador_palavras
// Word index counter for the accumulator sequencer. It is cleared when an
// operation is accepted and advances once per summed word. The terminal flag
// reports that the current index is the last word (i+1 == limite). The
// comparison is made one bit wider, so limite equal to the maximum count
// cannot wrap.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   zera       in   load index with 0
//   incrementa in   advance index by one
//   limite     in   ADDR_W  word count of the current operation
//   indice     out  ADDR_W  current word index
//   ultimo     out  1 when indice+1 == limite
// -----------------------------------------------------------------------------
module contador_palavras
   import acumulador_controle_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_PADRAO
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              zera,
   input  logic              incrementa,
   input  logic [ADDR_W-1:0] limite,
   output logic [ADDR_W-1:0] indice,
   output logic              ultimo
);

   logic [ADDR_W-1:0] indice_r;
   logic [ADDR_W:0]   proximo_s;

   // Index register: clearing takes priority over advancing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         indice_r <= {ADDR_W{1'b0}};
      end else if (zera) begin
         indice_r <= {ADDR_W{1'b0}};
      end else if (incrementa) begin
         indice_r <= indice_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         indice_r <= indice_r;
      end
   end

   // Terminal-count detection, widened by one bit.
   always_comb begin
      proximo_s = {1'b0, indice_r} + {{ADDR_W{1'b0}}, 1'b1};
      ultimo    = (proximo_s == {1'b0, limite});
   end

   assign indice = indice_r;

endmodule

// File: rtl/acumulador_controle.sv
// -----------------------------------------------------------------------------
// acumulador_controle
// Sequencer that sums a block of consecutive memory words on an external
// accumulator (Load, active-low Clear and Transfer, all edge-triggered on the
// accumulator side). When Start is accepted, the block clears the
// accumulator. It then reads Count words starting at Base. For each word it
// pulses Load and then Transfer. It then latches Acc into Result and issues a
// one-cycle Done pulse.
//
// Optional feature macro: ACUM_OVERFLOW_EN
//   defined   : sticky Overflow flag on accumulator carry-out, cleared when
//               Start is accepted
//   undefined : Overflow tied to 0, no adder
//
// Ports:
//   Clock    in   system clock, rising edge
//   Reset    in   asynchronous, active-high
//   Start    in   operation request, sampled only in IDLE
//   Base     in   ADDR_W   first word address (captured on accept)
//   Count    in   ADDR_W   number of words, 0 allowed (captured on accept)
//   MemData  in   TAMANHO  memory read data, valid the cycle after MemRd
//   Acc      in   TAMANHO  accumulator output
//   MemRd    out  memory read strobe
//   Addr     out  ADDR_W   memory address, holds outside LE
//   Load     out  accumulator operand-register clock pulse
//   Clear    out  accumulator clear, active-low
//   Transfer out  accumulator sum-register clock pulse
//   Busy     out  operation in progress
//   Done     out  one-cycle completion pulse
//   Result   out  TAMANHO  final sum, held until next Done
//   Overflow out  sticky carry-out flag
// -----------------------------------------------------------------------------
module acumulador_controle
   import acumulador_controle_pkg::*;
#(
   parameter int TAMANHO = TAMANHO_PADRAO,
   parameter int ADDR_W  = ADDR_W_PADRAO
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic [ADDR_W-1:0]  Base,
   input  logic [ADDR_W-1:0]  Count,
   input  logic [TAMANHO-1:0] MemData,
   input  logic [TAMANHO-1:0] Acc,
   output logic               MemRd,
   output logic [ADDR_W-1:0]  Addr,
   output logic               Load,
   output logic               Clear,
   output logic               Transfer,
   output logic               Busy,
   output logic               Done,
   output logic [TAMANHO-1:0] Result,
   output logic               Overflow
);

   estado_t            state_r;
   estado_t            state_s;
   logic               aceita_s;
   logic [ADDR_W-1:0]  base_r;
   logic [ADDR_W-1:0]  count_r;
   logic [ADDR_W-1:0]  indice_s;
   logic               ultimo_s;
   logic               memrd_r;
   logic               load_r;
   logic               clear_r;
   logic               transfer_r;
   logic               busy_r;
   logic               done_r;
   logic [ADDR_W-1:0]  addr_r;
   logic [TAMANHO-1:0] result_r;
   logic               overflow_r;

   // Word counter: restarts on accept, steps on every TRANSF cycle.
   contador_palavras #(
      .ADDR_W (ADDR_W)
   ) u_contador (
      .clk        (Clock),
      .rst        (Reset),
      .zera       (aceita_s),
      .incrementa (state_r == TRANSF),
      .limite     (count_r),
      .indice     (indice_s),
      .ultimo     (ultimo_s)
   );

   // Next-state logic. Start is only looked at in IDLE, so requests made
   // during an operation are dropped rather than queued.
   always_comb begin
      state_s  = state_r;
      aceita_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (Start) begin
               state_s  = LIMPA;
               aceita_s = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         LIMPA: begin
            if (count_r != {ADDR_W{1'b0}}) begin
               state_s = LE;
            end else begin
               state_s = FIM;
            end
         end
         LE:      state_s = CARREGA;
         CARREGA: state_s = TRANSF;
         TRANSF: begin
            if (ultimo_s) begin
               state_s = FIM;
            end else begin
               state_s = LE;
            end
         end
         FIM:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register plus operand capture on accept.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r <= IDLE;
         base_r  <= {ADDR_W{1'b0}};
         count_r <= {ADDR_W{1'b0}};
      end else begin
         state_r <= state_s;
         if (aceita_s) begin
            base_r  <= Base;
            count_r <= Count;
         end else begin
            base_r  <= base_r;
            count_r <= count_r;
         end
      end
   end

   // Registered strobes, decoded from the next state so that each strobe
   // lines up with its state. Clear resets low, which holds the accumulator
   // cleared for as long as Reset is asserted.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         memrd_r    <= 1'b0;
         load_r     <= 1'b0;
         clear_r    <= 1'b0;
         transfer_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         memrd_r    <= (state_s == LE);
         load_r     <= (state_s == CARREGA);
         clear_r    <= (state_s != LIMPA);
         transfer_r <= (state_s == TRANSF);
         busy_r     <= (state_s != IDLE);
      end
   end

   // Address register. The first LE loads Base. Each later LE follows a
   // TRANSF and steps by one, wrapping modulo 2^ADDR_W. The address holds
   // in every other state.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         addr_r <= {ADDR_W{1'b0}};
      end else if (state_s == LE) begin
         if (state_r == LIMPA) begin
            addr_r <= base_r;
         end else begin
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         end
      end else begin
         addr_r <= addr_r;
      end
   end

   // Completion: Result and Done update on the edge that leaves FIM.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         done_r   <= 1'b0;
         result_r <= {TAMANHO{1'b0}};
      end else begin
         done_r <= (state_r == FIM);
         if (state_r == FIM) begin
            result_r <= Acc;
         end else begin
            result_r <= result_r;
         end
      end
   end

`ifdef ACUM_OVERFLOW_EN
   logic [TAMANHO:0] soma_s;

   // Carry-out of the addition the accumulator performs for this word.
   always_comb begin
      soma_s = {1'b0, Acc} + {1'b0, MemData};
   end

   // Sticky overflow flag, restarted by each accepted operation.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         overflow_r <= 1'b0;
      end else if (aceita_s) begin
         overflow_r <= 1'b0;
      end else if ((state_r == CARREGA) && soma_s[TAMANHO]) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end
`else
   // Without the overflow feature, MemData is consumed only by the
   // accumulator. It is reduced here and deliberately left without a load.
   logic unused_memdata_s;
   assign unused_memdata_s = ^MemData;
   assign overflow_r       = 1'b0;
`endif

   assign MemRd    = memrd_r;
   assign Addr     = addr_r;
   assign Load     = load_r;
   assign Clear    = clear_r;
   assign Transfer = transfer_r;
   assign Busy     = busy_r;
   assign Done     = done_r;
   assign Result   = result_r;
   assign Overflow = overflow_r;

   // The index value itself is not needed here; only its terminal flag is.
   logic unused_indice_s;
   assign unused_indice_s = ^indice_s;

endmodule

// File: tb/tb_acumulador_controle.sv
// -----------------------------------------------------------------------------
// tb_acumulador_controle
// Self-checking bench for acumulador_controle. It provides a synchronous-read
// memory and a behavioural accumulator (operand register on Load, sum
// register on Transfer, asynchronous clear on Clear low). Expected sums,
// address sequences and cycle numbers come from plain arithmetic over the
// memory contents.
// -----------------------------------------------------------------------------
module tb_acumulador_controle;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Start;
   logic [7:0]  Base;
   logic [7:0]  Count;
   logic [15:0] MemData;
   logic [15:0] Acc;
   logic        MemRd;
   logic [7:0]  Addr;
   logic        Load;
   logic        Clear;
   logic        Transfer;
   logic        Busy;
   logic        Done;
   logic [15:0] Result;
   logic        Overflow;

   acumulador_controle #(.TAMANHO(16), .ADDR_W(8)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Base(Base), .Count(Count),
      .MemData(MemData), .Acc(Acc), .MemRd(MemRd), .Addr(Addr), .Load(Load),
      .Clear(Clear), .Transfer(Transfer), .Busy(Busy), .Done(Done),
      .Result(Result), .Overflow(Overflow)
   );

   always #5 Clock = ~Clock;

   // Synchronous-read memory
   logic [15:0] mem [0:255];
   always @(posedge Clock) if (MemRd) MemData <= mem[Addr];

   // Accumulator datapath stand-in
   logic [15:0] operando;
   always @(posedge Clock) if (Load) operando <= MemData;
   always @(posedge Clock or negedge Clear)
      if (!Clear) Acc <= 16'd0;
      else if (Transfer) Acc <= Acc + operando;

   int assertions = 0;
   int failures   = 0;

   // Observations of one operation
   int          obs_done_cycle, obs_done_count, obs_load, obs_transf, obs_memrd;
   int          obs_clear_low, obs_busy_bad;
   logic [7:0]  obs_addr [$];
   logic [15:0] obs_result, result_at_start;
   logic        obs_ovf, obs_ovf_c1, obs_result_changed;

   function automatic int ref_sum(input logic [7:0] b, input int n);
      int s = 0;
      logic [7:0] a = b;
      for (int k = 0; k < n; k++) begin
         s += int'(mem[a]);
         a = a + 8'd1;
      end
      return s;
   endfunction

   function automatic logic ref_ovf(input int s);
`ifdef ACUM_OVERFLOW_EN
      return (s > 65535);
`else
      return (s < 0);   // a sum is never negative: flag always expected 0
`endif
   endfunction

   // Issue Start so that the next edge is E0; return #1 into cycle 1.
   task automatic start_op(input logic [7:0] b, input logic [7:0] n);
      @(negedge Clock);
      Base = b; Count = n; Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0; Base = 8'($urandom); Count = 8'($urandom);
   endtask

   // Observe cycles 1..3n+8 of an operation (the caller is in cycle 1).
   task automatic observe_op(input int n, input bit spam, input bit chain,
                             input logic [7:0] cb, input logic [7:0] cn);
      int limit = 3 * n + 8;
      obs_done_cycle = -1; obs_done_count = 0; obs_load = 0; obs_transf = 0;
      obs_memrd = 0; obs_clear_low = 0; obs_busy_bad = 0; obs_addr.delete();
      obs_result = 16'hxxxx; obs_ovf = 1'bx; obs_result_changed = 1'b0;
      result_at_start = Result; obs_ovf_c1 = Overflow;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         if (cyc > 1) begin @(posedge Clock); #1; end
         if (MemRd) begin obs_memrd++; obs_addr.push_back(Addr); end
         if (Load) obs_load++;
         if (Transfer) obs_transf++;
         if (!Clear) obs_clear_low++;
         if (Busy !== (cyc <= 3 * n + 2)) obs_busy_bad++;
         if (Done) begin
            if (obs_done_count == 0) begin
               obs_done_cycle = cyc; obs_result = Result; obs_ovf = Overflow;
            end
            obs_done_count++;
         end else if (obs_done_count == 0 && Result !== result_at_start) begin
            obs_result_changed = 1'b1;
         end
         if (spam && cyc < 3 * n + 2) begin
            Start = 1'($urandom_range(0, 1)); Base = 8'($urandom); Count = 8'($urandom);
         end else begin
            Start = 1'b0;
         end
         if (chain && Done && obs_done_count == 1) begin
            Base = cb; Count = cn; Start = 1'b1;
            @(posedge Clock); #1;
            Start = 1'b0;
            return;
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; Base = 8'd0; Count = 8'd0;
      #12;
      assertions++;
      if ({MemRd, Load, Transfer, Clear, Busy, Done, Overflow} !== 7'b0) begin
         failures++;
         $display("FAIL reset_strobes got %b exp 0000000", {MemRd, Load, Transfer, Clear, Busy, Done, Overflow});
      end
      assertions++;
      if (Addr !== 8'd0 || Result !== 16'd0) begin
         failures++; $display("FAIL reset_addr_result got %0d/%0d exp 0/0", Addr, Result);
      end
      @(negedge Clock); Reset = 1'b0;
      @(posedge Clock); #1;
      assertions++;
      if (Clear !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
         failures++; $display("FAIL post_reset got Clear=%b Busy=%b Done=%b exp 1 0 0", Clear, Busy, Done);
      end
   endtask

   task automatic test_plan_example();
      mem[10] = 16'd3; mem[11] = 16'd5; mem[12] = 16'd7;
      start_op(8'd10, 8'd3);
      observe_op(3, 1'b0, 1'b0, 8'd0, 8'd0);
      assertions++;
      if (obs_load !== 3 || obs_transf !== 3 || obs_memrd !== 3) begin
         failures++; $display("FAIL plan_pulses got L%0d T%0d R%0d exp 3 3 3", obs_load, obs_transf, obs_memrd);
      end
      assertions++;
      if (obs_addr.size() != 3 || obs_addr[0] !== 8'd10 || obs_addr[1] !== 8'd11 || obs_addr[2] !== 8'd12) begin
         failures++; $display("FAIL plan_addr got %p exp 10 11 12", obs_addr);
      end
      assertions++;
      if (obs_done_cycle !== 12 || obs_done_count !== 1) begin
         failures++; $display("FAIL plan_done got cycle %0d count %0d exp 12 1", obs_done_cycle, obs_done_count);
      end
      assertions++;
      if (obs_result !== 16'd15) begin
         failures++; $display("FAIL plan_result got %0d exp 15", obs_result);
      end
      assertions++;
      if (obs_clear_low !== 1 || obs_busy_bad !== 0) begin
         failures++; $display("FAIL plan_clear_busy got clr%0d busybad%0d exp 1 0", obs_clear_low, obs_busy_bad);
      end
   endtask

   task automatic test_count_zero();
      start_op(8'd77, 8'd0);
      observe_op(0, 1'b0, 1'b0, 8'd0, 8'd0);
      assertions++;
      if (obs_clear_low !== 1 || obs_memrd !== 0 || obs_load !== 0 || obs_transf !== 0) begin
         failures++;
         $display("FAIL zero_strobes got clr%0d R%0d L%0d T%0d exp 1 0 0 0", obs_clear_low, obs_memrd, obs_load, obs_transf);
      end
      assertions++;
      if (obs_done_cycle !== 3 || obs_result !== 16'd0 || obs_busy_bad !== 0) begin
         failures++;
         $display("FAIL zero_done got cycle %0d result %0d busybad %0d exp 3 0 0", obs_done_cycle, obs_result, obs_busy_bad);
      end
   endtask

   task automatic test_wrap();
      int s;
      mem[255] = 16'h1234; mem[0] = 16'h0101;
      s = ref_sum(8'd255, 2);
      start_op(8'd255, 8'd2);
      observe_op(2, 1'b0, 1'b0, 8'd0, 8'd0);
      assertions++;
      if (obs_addr.size() != 2 || obs_addr[0] !== 8'd255 || obs_addr[1] !== 8'd0) begin
         failures++; $display("FAIL wrap_addr got %p exp 255 0", obs_addr);
      end
      assertions++;
      if (obs_result !== s[15:0] || obs_done_cycle !== 9) begin
         failures++; $display("FAIL wrap_result got %h@%0d exp %h@9", obs_result, obs_done_cycle, s[15:0]);
      end
   endtask

   task automatic test_random_ops();
      for (int t = 0; t < 8; t++) begin
         logic [7:0] b = 8'($urandom);
         int n = $urandom_range(0, 9);
         int s = ref_sum(b, n);
         start_op(b, 8'(n));
         observe_op(n, 1'b0, 1'b0, 8'd0, 8'd0);
         assertions++;
         if (obs_result !== s[15:0] || obs_done_cycle !== 3 * n + 3 || obs_done_count !== 1) begin
            failures++;
            $display("FAIL rand%0d_done got %h@%0dx%0d exp %h@%0dx1", t, obs_result, obs_done_cycle, obs_done_count, s[15:0], 3 * n + 3);
         end
         assertions++;
         if (obs_load !== n || obs_transf !== n || obs_memrd !== n || obs_busy_bad !== 0) begin
            failures++;
            $display("FAIL rand%0d_pulses got L%0d T%0d R%0d bb%0d exp %0d", t, obs_load, obs_transf, obs_memrd, obs_busy_bad, n);
         end
         for (int k = 0; k < n && k < obs_addr.size(); k++) begin
            logic [7:0] ea = b + 8'(k);
            assertions++;
            if (obs_addr[k] !== ea) begin
               failures++; $display("FAIL rand%0d_addr%0d got %0d exp %0d", t, k, obs_addr[k], ea);
            end
         end
         assertions++;
         if (obs_ovf !== ref_ovf(s)) begin
            failures++; $display("FAIL rand%0d_ovf got %b exp %b", t, obs_ovf, ref_ovf(s));
         end
      end
   endtask

   task automatic test_start_during_busy();
      int s = ref_sum(8'd100, 5);
      start_op(8'd100, 8'd5);
      observe_op(5, 1'b1, 1'b0, 8'd0, 8'd0);
      assertions++;
      if (obs_done_count !== 1 || obs_done_cycle !== 18 || obs_busy_bad !== 0) begin
         failures++;
         $display("FAIL busy_start got done %0dx%0d busybad %0d exp 18x1 0", obs_done_cycle, obs_done_count, obs_busy_bad);
      end
      assertions++;
      if (obs_result !== s[15:0] || obs_load !== 5) begin
         failures++; $display("FAIL busy_result got %h L%0d exp %h L5", obs_result, obs_load, s[15:0]);
      end
   endtask

   task automatic test_back_to_back();
      int s1 = ref_sum(8'd20, 4);
      int s2 = ref_sum(8'd200, 3);
      start_op(8'd20, 8'd4);
      observe_op(4, 1'b0, 1'b1, 8'd200, 8'd3);
      assertions++;
      if (obs_result !== s1[15:0] || obs_done_cycle !== 15) begin
         failures++; $display("FAIL b2b_first got %h@%0d exp %h@15", obs_result, obs_done_cycle, s1[15:0]);
      end
      observe_op(3, 1'b0, 1'b0, 8'd0, 8'd0);
      assertions++;
      if (result_at_start !== s1[15:0] || obs_result_changed !== 1'b0) begin
         failures++; $display("FAIL b2b_hold got %h changed %b exp %h 0", result_at_start, obs_result_changed, s1[15:0]);
      end
      assertions++;
      if (obs_result !== s2[15:0] || obs_done_cycle !== 12 || obs_addr.size() != 3 || obs_addr[0] !== 8'd200) begin
         failures++; $display("FAIL b2b_second got %h@%0d exp %h@12", obs_result, obs_done_cycle, s2[15:0]);
      end
   endtask

   task automatic test_reset_mid_op();
      int bad = 0;
      int s;
      start_op(8'd30, 8'd3);
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      assertions++;
      if (Load !== 1'b1) begin
         failures++; $display("FAIL midrst_in_carrega got Load=%b exp 1", Load);
      end
      Reset = 1'b1; #1;
      assertions++;
      if ({MemRd, Load, Transfer, Clear, Busy, Done, Overflow} !== 7'b0 || Addr !== 8'd0 || Result !== 16'd0) begin
         failures++;
         $display("FAIL midrst_outputs got %b addr %0d result %h exp 0", {MemRd, Load, Transfer, Clear, Busy, Done, Overflow}, Addr, Result);
      end
      @(negedge Clock); Reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge Clock); #1;
         if (Done !== 1'b0 || Busy !== 1'b0 || Clear !== 1'b1) bad++;
      end
      assertions++;
      if (bad !== 0) begin
         failures++; $display("FAIL midrst_no_done got %0d bad cycles exp 0", bad);
      end
      s = ref_sum(8'd30, 3);
      start_op(8'd30, 8'd3);
      observe_op(3, 1'b0, 1'b0, 8'd0, 8'd0);
      assertions++;
      if (obs_result !== s[15:0] || obs_done_cycle !== 12 || obs_load !== 3) begin
         failures++; $display("FAIL midrst_rerun got %h@%0d L%0d exp %h@12 L3", obs_result, obs_done_cycle, obs_load, s[15:0]);
      end
   endtask

   task automatic test_overflow();
      mem[40] = 16'hFFFF; mem[41] = 16'h0002;
      mem[50] = 16'h0001; mem[51] = 16'h0002;
      start_op(8'd40, 8'd2);
      observe_op(2, 1'b0, 1'b0, 8'd0, 8'd0);
      assertions++;
      if (obs_result !== 16'h0001 || obs_ovf !== ref_ovf(32'h0001_0001)) begin
         failures++;
         $display("FAIL ovf_set got %h ovf %b exp 0001 ovf %b", obs_result, obs_ovf, ref_ovf(32'h0001_0001));
      end
      start_op(8'd50, 8'd2);
      observe_op(2, 1'b0, 1'b0, 8'd0, 8'd0);
      assertions++;
      if (obs_ovf_c1 !== 1'b0 || obs_ovf !== 1'b0 || obs_result !== 16'h0003) begin
         failures++; $display("FAIL ovf_clear got c1 %b done %b result %h exp 0 0 0003", obs_ovf_c1, obs_ovf, obs_result);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      test_reset();
      test_plan_example();
      test_count_zero();
      test_wrap();
      test_random_ops();
      test_start_during_busy();
      test_back_to_back();
      test_reset_mid_op();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
